// File: rtl/usb_report_pkg.sv
// usb_report_pkg
// Shared constants for the darfon/dragonrise 8-byte HID joystick report:
// byte and bit positions inside the report, NES button input positions,
// axis values, hat codes, the neutral report and the encoder FSM states.
// Optional build macro used by the report builder: USB_REPORT_ENCODER_HAT_EN.

package usb_report_pkg;

  // Report byte positions (byte0 = report[7:0])
  localparam int C_BYTE_X     = 0;
  localparam int C_BYTE_Y     = 1;
  localparam int C_BYTE_Z     = 2;
  localparam int C_BYTE_RX    = 3;
  localparam int C_BYTE_RY    = 4;
  localparam int C_BYTE_BTN0  = 5;
  localparam int C_BYTE_BTN1  = 6;
  localparam int C_BYTE_RSVD  = 7;

  // Bit positions inside the button bytes
  localparam int C_BIT_A      = 6;  // byte5
  localparam int C_BIT_B      = 5;  // byte5
  localparam int C_BIT_START  = 5;  // byte6
  localparam int C_BIT_SELECT = 4;  // byte6

  // NES button input positions (1 = pressed)
  localparam int C_IN_A      = 0;
  localparam int C_IN_B      = 1;
  localparam int C_IN_SELECT = 2;
  localparam int C_IN_START  = 3;
  localparam int C_IN_U      = 4;
  localparam int C_IN_D      = 5;
  localparam int C_IN_L      = 6;
  localparam int C_IN_R      = 7;

  // Axis values
  localparam logic [7:0] C_AXIS_MIN = 8'h00;
  localparam logic [7:0] C_AXIS_MID = 8'h7F;
  localparam logic [7:0] C_AXIS_MAX = 8'hFF;

  // Hat codes, clockwise from up
  localparam logic [3:0] C_HAT_U    = 4'h0;
  localparam logic [3:0] C_HAT_UR   = 4'h1;
  localparam logic [3:0] C_HAT_R    = 4'h2;
  localparam logic [3:0] C_HAT_DR   = 4'h3;
  localparam logic [3:0] C_HAT_D    = 4'h4;
  localparam logic [3:0] C_HAT_DL   = 4'h5;
  localparam logic [3:0] C_HAT_L    = 4'h6;
  localparam logic [3:0] C_HAT_UL   = 4'h7;
  localparam logic [3:0] C_HAT_NONE = 4'hF;

  // Nothing pressed: axes centred, hat released, no buttons
  localparam logic [63:0] C_REPORT_NEUTRAL = 64'h0000_0F7F_7F7F_7F7F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_t;

  // One axis from its two (already cancelled) direction bits
  function automatic logic [7:0] axis_code(input logic neg, input logic pos);
    logic [7:0] v;
    v = C_AXIS_MID;
    if (neg)      v = C_AXIS_MIN;
    else if (pos) v = C_AXIS_MAX;
    return v;
  endfunction

endpackage

// File: rtl/usb_report_encoder_if.sv
// usb_report_encoder_if
// Report handshake between the encoder (master) and the report
// transmitter (slave).
//   o_report        64  HID report, byte0 = bits [7:0]
//   o_report_valid   1  report available, held until accepted
//   i_report_ready   1  transmitter accepts the report

interface usb_report_encoder_if;
  logic [63:0] o_report;
  logic        o_report_valid;
  logic        i_report_ready;

  modport master (
    output o_report,
    output o_report_valid,
    input  i_report_ready
  );

  modport slave (
    input  o_report,
    input  o_report_valid,
    output i_report_ready
  );
endinterface

// File: rtl/usb_report_build.sv
// usb_report_build
// Purely combinational map from the 8-bit NES button state to the 64-bit
// HID joystick report. Also usable as a reference model by decoder benches.
// Build macro USB_REPORT_ENCODER_HAT_EN: when defined the d-pad is reported
// on the hat nibble (byte5[3:0]) with both axes fixed at centre; when
// undefined the d-pad drives the X/Y axes and the hat stays released.
// Ports:
//   btn     in   8  [7]R [6]L [5]D [4]U [3]start [2]select [1]B [0]A
//   report  out 64  HID report, byte0 = bits [7:0]

module usb_report_build
  import usb_report_pkg::*;
(
  input  logic [7:0]  btn,
  output logic [63:0] report
);

  logic dir_u;
  logic dir_d;
  logic dir_l;
  logic dir_r;

  // Opposing directions cancel to centre on that axis
  assign dir_u = btn[C_IN_U] & ~btn[C_IN_D];
  assign dir_d = btn[C_IN_D] & ~btn[C_IN_U];
  assign dir_l = btn[C_IN_L] & ~btn[C_IN_R];
  assign dir_r = btn[C_IN_R] & ~btn[C_IN_L];

`ifdef USB_REPORT_ENCODER_HAT_EN
  logic [3:0] hat;

  always_comb begin
    hat = C_HAT_NONE;
    case ({dir_u, dir_d, dir_l, dir_r})
      4'b1000: hat = C_HAT_U;
      4'b1001: hat = C_HAT_UR;
      4'b0001: hat = C_HAT_R;
      4'b0101: hat = C_HAT_DR;
      4'b0100: hat = C_HAT_D;
      4'b0110: hat = C_HAT_DL;
      4'b0010: hat = C_HAT_L;
      4'b1010: hat = C_HAT_UL;
      default: hat = C_HAT_NONE;
    endcase
  end
`endif

  always_comb begin
    report = C_REPORT_NEUTRAL;
`ifdef USB_REPORT_ENCODER_HAT_EN
    report[C_BYTE_BTN0*8 +: 4] = hat;
`else
    report[C_BYTE_X*8 +: 8]    = axis_code(dir_l, dir_r);
    report[C_BYTE_Y*8 +: 8]    = axis_code(dir_u, dir_d);
`endif
    report[C_BYTE_BTN0*8 + C_BIT_A]      = btn[C_IN_A];
    report[C_BYTE_BTN0*8 + C_BIT_B]      = btn[C_IN_B];
    report[C_BYTE_BTN1*8 + C_BIT_START]  = btn[C_IN_START];
    report[C_BYTE_BTN1*8 + C_BIT_SELECT] = btn[C_IN_SELECT];
  end

endmodule

// File: rtl/usb_report_encoder.sv
// usb_report_encoder
// Turns the NES button state into 8-byte HID joystick reports. A report is
// queued on every button change, once after reset, and (when c_idle_hz is
// non-zero) as an idle repeat after c_clk_hz/c_idle_hz idle cycles.
// The d-pad encoding is selected in usb_report_build by the build macro
// USB_REPORT_ENCODER_HAT_EN.
// Parameters:
//   c_clk_hz   i_clk frequency in Hz
//   c_idle_hz  idle-repeat rate in Hz, 0 disables repeats
// Ports:
//   i_clk    in   1  core clock
//   i_rst_n  in   1  asynchronous active-low reset
//   i_btn    in   8  button state, 1 = pressed
//   rpt      master modport of usb_report_encoder_if (report handshake)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no report pending; watch for change, re-send flag, idle expiry
// ST_SEND | latched report presented with valid, waiting for ready

module usb_report_encoder
  import usb_report_pkg::*;
#(
  parameter int c_clk_hz  = 6000000,
  parameter int c_idle_hz = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [7:0]                  i_btn,
  usb_report_encoder_if.master        rpt
);

  localparam int C_PERIOD   = (c_idle_hz == 0) ? 1 : (c_clk_hz / c_idle_hz);
  localparam int C_IDLE_W   = (C_PERIOD > 1) ? $clog2(C_PERIOD) : 1;
  localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(C_PERIOD - 1);
  localparam bit C_IDLE_EN  = (c_idle_hz != 0);

  enc_state_t          state;
  enc_state_t          state_nxt;
  logic                load;
  logic                hs;
  logic                idle_exp;
  logic                changed;

  logic [7:0]          r_btn;
  logic [7:0]          r_sent;
  logic [7:0]          r_btn_lat;
  logic                r_pend;
  logic                r_live;
  logic [C_IDLE_W-1:0] r_idle;
  logic [63:0]         r_report;
  logic [63:0]         build_report;

  usb_report_build u_build (
    .btn    (r_btn),
    .report (build_report)
  );

  assign hs       = (state == ST_SEND) && rpt.i_report_ready;
  assign changed  = (r_btn != r_sent);
  assign idle_exp = C_IDLE_EN && (state == ST_IDLE) && (r_idle == C_IDLE_LAST);

  // Valid comes straight from the state register so an asynchronous reset
  // withdraws it without waiting for a clock edge.
  assign rpt.o_report_valid = (state == ST_SEND);
  assign rpt.o_report       = r_report;

  // r_live holds the FSM off for the first edge after reset release, so the
  // power-on report appears after the second edge like a button change does.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (r_live && (r_pend || changed || idle_exp)) begin
          state_nxt = ST_SEND;
          load      = 1'b1;
        end
      end
      ST_SEND: begin
        if (rpt.i_report_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      r_btn     <= 8'h00;
      r_sent    <= 8'h00;
      r_btn_lat <= 8'h00;
      r_pend    <= 1'b1;
      r_live    <= 1'b0;
      r_report  <= C_REPORT_NEUTRAL;
    end else begin
      state  <= state_nxt;
      r_btn  <= i_btn;
      r_live <= 1'b1;
      if (load) begin
        r_report  <= build_report;
        r_btn_lat <= r_btn;
      end
      if (hs) begin
        r_sent <= r_btn_lat;
        r_pend <= 1'b0;
      end
    end
  end

  // Idle counter: restarts on every accepted report, counts IDLE cycles and
  // parks at the terminal value until the resulting report is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle <= '0;
    end else if (hs) begin
      r_idle <= '0;
    end else if (C_IDLE_EN && (state == ST_IDLE) && (r_idle != C_IDLE_LAST)) begin
      r_idle <= r_idle + C_IDLE_W'(1);
    end
  end

endmodule
